// File: rtl/cordic_cos_fx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_cos_fx : iterative CORDIC cos(angle), Q2.22 in/out, start/done handshake.
// Optional sin_fx output under CORDIC_SIN_OUT_EN.   Revision 1.0
// ---------------------------------------------------------------------------
module cordic_cos_fx #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [23:0] angle_fx,
  output logic        done,
  output logic        busy,
  output logic [23:0] cos_fx
`ifdef CORDIC_SIN_OUT_EN
  ,
  output logic [23:0] sin_fx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic signed [25:0] K_INIT = 26'sh026DD3B;
  localparam logic [4:0]         LAST_I = 5'(ITER - 1);

  // round(atan(2^-i) * 2^22)
  localparam logic [25:0] ATAN_TAB [22] = '{
    26'h03243F7, 26'h01DAC67, 26'h00FADBA, 26'h007F56F,
    26'h003FEAB, 26'h001FFD5, 26'h000FFFB, 26'h0007FFF,
    26'h0004000, 26'h0002000, 26'h0001000, 26'h0000800,
    26'h0000400, 26'h0000200, 26'h0000100, 26'h0000080,
    26'h0000040, 26'h0000020, 26'h0000010, 26'h0000008,
    26'h0000004, 26'h0000002
  };

  state_t            state_q, state_d;
  logic signed [25:0] x_q, x_d;
  logic signed [25:0] y_q, y_d;
  logic signed [25:0] z_q, z_d;
  logic [4:0]        i_q, i_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [23:0]       cos_q, cos_d;
`ifdef CORDIC_SIN_OUT_EN
  logic [23:0]       sin_q, sin_d;
`endif

  // Clamp to 24 bits when the two guard bits and the 24-bit sign disagree.
  function automatic logic [23:0] sat24(input logic signed [25:0] v);
    if (v[25:23] == 3'b000 || v[25:23] == 3'b111) begin
      sat24 = v[23:0];
    end else begin
      sat24 = v[25] ? 24'h800000 : 24'h7FFFFF;
    end
  endfunction

  logic signed [25:0] x_sh, y_sh;
  logic [25:0]        atan_i;

  assign x_sh   = x_q >>> i_q;
  assign y_sh   = y_q >>> i_q;
  assign atan_i = ATAN_TAB[i_q];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    cos_d   = cos_q;
`ifdef CORDIC_SIN_OUT_EN
    sin_d   = sin_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && clk_en) begin
          x_d     = K_INIT;
          y_d     = '0;
          z_d     = {{2{angle_fx[23]}}, angle_fx};
          i_d     = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (clk_en) begin
          if (!z_q[25]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - $signed(atan_i);
          end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + $signed(atan_i);
          end
          i_d = i_q + 5'd1;
          if (i_q == LAST_I) begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        cos_d   = sat24(x_q);
`ifdef CORDIC_SIN_OUT_EN
        sin_d   = sat24(y_q);
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cos_q   <= '0;
`ifdef CORDIC_SIN_OUT_EN
      sin_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cos_q   <= cos_d;
`ifdef CORDIC_SIN_OUT_EN
      sin_q   <= sin_d;
`endif
    end
  end

  assign done   = done_q;
  assign busy   = busy_q;
  assign cos_fx = cos_q;
`ifdef CORDIC_SIN_OUT_EN
  assign sin_fx = sin_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_cos_fx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cordic_cos_fx : directed self-checking bench for cordic_cos_fx (ITER=16).
// ---------------------------------------------------------------------------
module tb_cordic_cos_fx;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [23:0] angle_fx;
  logic        done;
  logic        busy;
  logic [23:0] cos_fx;
`ifdef CORDIC_SIN_OUT_EN
  logic [23:0] sin_fx;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [23:0] COS_075 = 24'h2ED3FD;
  localparam logic [23:0] COS_0   = 24'h400000;
  localparam int          TOL     = 64;

  cordic_cos_fx #(.ITER(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .start    (start),
    .angle_fx (angle_fx),
    .done     (done),
    .busy     (busy),
    .cos_fx   (cos_fx)
`ifdef CORDIC_SIN_OUT_EN
    ,
    .sin_fx   (sin_fx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic int absdiff(input logic [23:0] a, input logic [23:0] b);
    int d;
    d = int'($signed(a)) - int'($signed(b));
    return (d < 0) ? -d : d;
  endfunction

  // Launch one operation, optionally freezing clk_en for stall_len edges
  // after stall_after edges; returns edges from acceptance until done is seen.
  task automatic run_op(input logic [23:0] ang, input int stall_after,
                        input int stall_len, output int edges);
    angle_fx = ang;
    start    = 1'b1;
    clk_en   = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    angle_fx = 24'h5A5A5A;
    edges    = 0;
    while (edges < 100) begin
      if (stall_len > 0 && edges == stall_after) clk_en = 1'b0;
      if (stall_len > 0 && edges == stall_after + stall_len) clk_en = 1'b1;
      @(posedge clk); #1;
      edges++;
      if (done) break;
    end
    clk_en = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (cos_fx !== 24'h0) begin n_fail++; $display("FAIL reset_cos: got %h want 000000", cos_fx); end
`ifdef CORDIC_SIN_OUT_EN
    n_checks++;
    if (sin_fx !== 24'h0) begin n_fail++; $display("FAIL reset_sin: got %h want 000000", sin_fx); end
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cos_075();
    int e;
    angle_fx = 24'h300000;
    start    = 1'b1;
    clk_en   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept: got %b want 1", busy); end
    e = 0;
    while (e < 100) begin
      @(posedge clk); #1;
      e++;
      if (done) break;
    end
    n_checks++;
    if (e !== 17) begin n_fail++; $display("FAIL latency_075: got %0d edges want 17", e); end
    n_checks++;
    if (absdiff(cos_fx, COS_075) > TOL) begin
      n_fail++; $display("FAIL cos_075: got %h want %h +-%0d", cos_fx, COS_075, TOL);
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_during_done: got %b want 1", busy); end
`ifdef CORDIC_SIN_OUT_EN
    n_checks++;
    if (absdiff(sin_fx, 24'h2B9FE9) > TOL) begin
      n_fail++; $display("FAIL sin_075: got %h want 2b9fe9 +-%0d", sin_fx, TOL);
    end
`endif
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", done); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b want 0", busy); end
  endtask

  task automatic test_cos_zero_neg();
    int e;
    run_op(24'h000000, 0, 0, e);
    n_checks++;
    if (e !== 17) begin n_fail++; $display("FAIL latency_zero: got %0d want 17", e); end
    n_checks++;
    if (absdiff(cos_fx, COS_0) > TOL) begin
      n_fail++; $display("FAIL cos_zero: got %h want %h +-%0d", cos_fx, COS_0, TOL);
    end
    @(posedge clk); #1;
    run_op(24'hD00000, 0, 0, e);
    n_checks++;
    if (absdiff(cos_fx, COS_075) > TOL) begin
      n_fail++; $display("FAIL cos_neg075: got %h want %h +-%0d", cos_fx, COS_075, TOL);
    end
`ifdef CORDIC_SIN_OUT_EN
    n_checks++;
    if (absdiff(sin_fx, 24'hD46017) > TOL) begin
      n_fail++; $display("FAIL sin_neg075: got %h want d46017 +-%0d", sin_fx, TOL);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_range_edge();
    int e;
    run_op(24'h600000, 0, 0, e);
    n_checks++;
    if (e !== 17) begin n_fail++; $display("FAIL latency_1p5: got %0d want 17", e); end
    n_checks++;
    if (cos_fx[23] !== 1'b0) begin n_fail++; $display("FAIL cos_1p5_sign: got %h want positive", cos_fx); end
    @(posedge clk); #1;
  endtask

  task automatic test_clk_en_stall();
    int e;
    run_op(24'h300000, 5, 5, e);
    n_checks++;
    if (e !== 22) begin n_fail++; $display("FAIL latency_stall: got %0d want 22", e); end
    n_checks++;
    if (absdiff(cos_fx, COS_075) > TOL) begin
      n_fail++; $display("FAIL cos_stall: got %h want %h +-%0d", cos_fx, COS_075, TOL);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int e;
    int extra;
    angle_fx = 24'h300000;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0;
    while (e < 100) begin
      start    = (e == 4 || e == 16);
      angle_fx = start ? 24'h000000 : 24'h5A5A5A;
      @(posedge clk); #1;
      e++;
      if (done) break;
    end
    start = 1'b0;
    n_checks++;
    if (e !== 17) begin n_fail++; $display("FAIL latency_ignored: got %0d want 17", e); end
    n_checks++;
    if (absdiff(cos_fx, COS_075) > TOL) begin
      n_fail++; $display("FAIL cos_ignored: got %h want %h +-%0d", cos_fx, COS_075, TOL);
    end
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL no_queued_op: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int e;
    angle_fx = 24'h300000;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    n_checks++;
    if (cos_fx !== 24'h0) begin n_fail++; $display("FAIL midreset_cos: got %h want 000000", cos_fx); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b want 0", done); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(24'h300000, 0, 0, e);
    n_checks++;
    if (e !== 17) begin n_fail++; $display("FAIL latency_after_reset: got %0d want 17", e); end
    n_checks++;
    if (absdiff(cos_fx, COS_075) > TOL) begin
      n_fail++; $display("FAIL cos_after_reset: got %h want %h +-%0d", cos_fx, COS_075, TOL);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    // Called while done is high: the new start is taken on the edge done falls.
    angle_fx = 24'h000000;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    e = 0;
    while (e < 100) begin
      @(posedge clk); #1;
      e++;
      if (done) break;
    end
    n_checks++;
    if (e !== 17) begin n_fail++; $display("FAIL b2b_latency: got %0d want 17", e); end
    n_checks++;
    if (absdiff(cos_fx, COS_0) > TOL) begin
      n_fail++; $display("FAIL b2b_cos: got %h want %h +-%0d", cos_fx, COS_0, TOL);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset    = 1'b0;
    clk_en   = 1'b0;
    start    = 1'b0;
    angle_fx = 24'h0;
    repeat (3) @(negedge clk);
    test_reset();
    test_cos_075();
    test_cos_zero_neg();
    test_range_edge();
    test_clk_en_stall();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cordic_cos_fx.md
# cordic_cos_fx

Iterative CORDIC engine that takes a signed Q2.22 angle in radians from the float-to-fixed stage and produces cos(angle) in the same Q2.22 format. It runs one rotation per enabled clock and uses a Nios II multicycle custom-instruction handshake (`start`/`done`). Its result feeds the fixed-to-float stage.

## Interface
- `ITER`, default 16: number of CORDIC iterations; legal range 8..22.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  clock enable; when low, all state holds.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `angle_fx`  in  24  signed Q2.22 angle, two's complement, radians; captured when the start is accepted.
- `done`  out  1  one-cycle pulse: `cos_fx` is valid from this cycle on.
- `busy`  out  1  high from start acceptance until `done` is issued.
- `cos_fx`  out  24  signed Q2.22 cosine; holds its value until the next `done`.
- `sin_fx`  out  24  signed Q2.22 sine; present only with `CORDIC_SIN_OUT_EN`.

## Operation
- The FSM has three states: IDLE, RUN, FIN.
- **IDLE:**
  - If `start` and `clk_en` are both high, load `x = 0x26DD3B` (K = 0.6072529, Q2.22), `y = 0`, `z = angle_fx`, iteration counter `i = 0`, then go to RUN.
  - Otherwise remain in IDLE.
- **RUN**, on each clock with `clk_en` high:
  - Let d = +1 if z ≥ 0, otherwise −1.
  - x' = x − d·(y>>>i), y' = y + d·(x>>>i), z' = z − d·atan_tab[i]. Shifts are arithmetic.
  - Increment `i`. The iteration with i = ITER−1 moves the FSM to FIN.
- **FIN:** register x into `cos_fx` (and y into `sin_fx`), pulse `done` for one cycle, return to IDLE. This happens regardless of `clk_en`.
- **Arctangent table:** atan_tab[i] = round(atan(2^-i)·2^22). Entry 0 is 0x3243F7, entry 1 is 0x1DAC67, entry 2 is 0x0FADBA. The table is a localparam array with 22 entries.
- **Datapath width:**
  - x, y and z are 26 bits internally (2 guard MSBs).
  - Outputs are the low 24 bits, saturated to 0x7FFFFF / 0x800000 if the guard bits disagree.
- **Valid input range:** |angle_fx| ≤ 1.5 rad (0x600000). Outside this range the result is unspecified, but the FSM still completes and issues `done`.
- **Accuracy:** for ITER = 16, |cos_fx − cos(angle)| ≤ 64 LSB (≈1.5e-5).
- **Start while busy:** `start` in RUN or FIN is ignored. No queueing, no error flag.
- **Reset mid-operation:**
  - FSM returns to IDLE immediately.
  - `done`, `busy`, `cos_fx`, `sin_fx` = 0.
  - The partial result is discarded.

## Timing
- **Reset values:** `done` = 0, `busy` = 0, `cos_fx` = 0, `sin_fx` = 0, state = IDLE, `i` = 0.
- **Latency with `clk_en` held high:**
  - `start` is sampled at edge E0.
  - `busy` goes high after E0.
  - `done` is high during the cycle after edge E0+ITER+1, i.e. ITER+1 edges after acceptance; 17 for the default.
  - `busy` falls on the same edge that `done` falls.
- **`clk_en` low during RUN:**
  - Freezes x, y, z and `i`.
  - Latency stretches by exactly the number of disabled cycles.
- **Back-to-back operation:** a new `start` is accepted in the cycle `done` falls (IDLE). Throughput is one result per ITER+2 cycles.
- **Input stability:** `angle_fx` needs to be stable only at the accepting edge.

## Configuration
- `CORDIC_SIN_OUT_EN` defined:
  - The `sin_fx` port exists and is registered in FIN alongside `cos_fx`.
  - Its reset value is 0.
  - Accuracy matches `cos_fx`.
- `CORDIC_SIN_OUT_EN` undefined:
  - The `sin_fx` port and its output register are removed.
  - The y datapath remains, since it is needed for cos.
  - Behaviour and timing are otherwise identical.

## Test plan
- Reset low, then high; `start` with `angle_fx` = 0x300000 (0.75) and `clk_en` = 1 → `done` after 17 edges; `cos_fx` = 0x2ED3FD ±64; `busy` low afterwards.
- `angle_fx` = 0x000000 → `cos_fx` = 0x400000 ±64. `angle_fx` = 0xD00000 (−0.75) → `cos_fx` = 0x2ED3FD ±64.
- With the macro defined, `angle_fx` = 0x300000 → `sin_fx` = 0x2B9FE9 ±64. `angle_fx` = 0xD00000 → `sin_fx` = 0xD46017 ±64.
- Drop `clk_en` for 5 cycles mid-RUN → `done` arrives after 22 edges; result is unchanged from the first scenario.
- Pulse `start` with 0x000000 during RUN of a 0.75 operation → it is ignored and `cos_fx` = 0x2ED3FD. Pulse `reset` low at iteration 8 → outputs read 0 and `busy` = 0 immediately; the next `start` completes normally.
